// File: rtl/sram_ctrl_if.sv
// Command/response bus of the clocked SRAM controller.
// The master side issues commands and clear requests; the slave side owns the memory array.
interface sram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_be;
    logic                      clear_start;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, clear_start,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, clear_start,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Clocked SRAM controller: valid/ready commands, byte-enable writes,
// pipelined in-order responses and a one-word-per-cycle hardware clear sweep.
module sram_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    sram_ctrl_if.slave   bus
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    started;
    logic [CNT_WIDTH-1:0]    clr_cnt;
    logic [CNT_WIDTH-1:0]    clr_cnt_next;
    logic                    cmd_ready;
    logic                    busy;

    logic                    fire_c;
    logic                    in_range_c;
    logic [CNT_WIDTH-1:0]    cmd_idx_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;

    logic                    mem_we_c;
    logic [CNT_WIDTH-1:0]    mem_waddr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic [BE_WIDTH-1:0]     mem_wbe_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [READ_LATENCY-1:0]                 pipe_valid;
    logic [READ_LATENCY-1:0]                 pipe_err;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_data;

    // Command decode; out-of-range addresses never touch the array.
    always_comb begin
        fire_c     = bus.cmd_valid && cmd_ready;
        in_range_c = 32'(bus.cmd_addr) < 32'(DEPTH);
        cmd_idx_c  = CNT_WIDTH'(bus.cmd_addr);
        rd_data_c  = '0;
        if (fire_c && !bus.cmd_write && in_range_c) begin
            rd_data_c = mem[cmd_idx_c];
        end
    end

    // Single write port shared by the clear sweep and accepted writes.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = cmd_idx_c;
        mem_wdata_c = bus.cmd_wdata;
        mem_wbe_c   = bus.cmd_be;
        if (started && state == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_cnt;
            mem_wdata_c = '0;
            mem_wbe_c   = '1;
        end else if (fire_c && bus.cmd_write && in_range_c) begin
            mem_we_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (mem_wbe_c[b]) begin
                    mem[mem_waddr_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
                end
            end
        end
    end

    // Next-state logic; the first edge after reset picks the power-up mode.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (!started) begin
            state_next   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clear_start) begin
                        state_next   = ST_CLEAR;
                        clr_cnt_next = '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CNT_WIDTH'(DEPTH - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        clr_cnt_next = clr_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            started   <= 1'b0;
            clr_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            started   <= 1'b1;
            clr_cnt   <= clr_cnt_next;
            cmd_ready <= (state_next == ST_IDLE);
            busy      <= (state_next == ST_CLEAR);
        end
    end

    // Response shift pipeline; data/err stay zero in empty slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= fire_c;
            pipe_err[0]   <= fire_c && !in_range_c;
            pipe_data[0]  <= rd_data_c;
            for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = busy;
    assign bus.rsp_valid = pipe_valid[READ_LATENCY-1];
    assign bus.rsp_err   = pipe_err[READ_LATENCY-1];
    assign bus.rsp_rdata = pipe_data[READ_LATENCY-1];

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised, clocked successor to the PIO-driven 8-bit x 2048 SRAM.
- Replaces the level-driven ReadWrite/enable/bidirectional-data interface with:
  - a valid/ready command port,
  - per-byte write enables,
  - a configurable pipelined read latency,
  - a hardware clear sweep.
- Sits behind the NIOS II PIO bridge (or any master) and owns the memory array internally.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11: address port width.
- DEPTH, 2048: implemented words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from command acceptance to response; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = automatic clear sweep after reset deassertion; 0 = none.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  word address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_be  in  DATA_WIDTH/8  byte enables for writes; bit i covers byte i.
- clear_start  in  1  pulse: zero the whole array.
- rsp_valid  out  1  response strobe, one cycle wide.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  address out of range, valid with rsp_valid.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset:
  - Asynchronous assert clears every output to 0 (cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0).
  - Response pipeline flushed, clear counter=0.
  - The array itself has no reset.
  - After deassertion: next state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- FSM, two states:
  - IDLE: cmd_ready=1, busy=0.
    - clear_start=1 -> CLEAR on the next edge, counter=0.
  - CLEAR: cmd_ready=0, busy=1.
    - Writes word[counter]=0 with all bytes enabled, one word per cycle.
    - counter==DEPTH-1 -> IDLE after that write.
    - Sweep takes exactly DEPTH cycles.
    - clear_start is ignored while in CLEAR.
- Acceptance: a command fires on an edge where cmd_valid && cmd_ready. At most one command per cycle; no input buffering.
- Every fired command produces exactly one response:
  - Command fires at edge T -> rsp_valid=1 for the cycle after edge T+READ_LATENCY-1, i.e. visible READ_LATENCY cycles after acceptance.
  - Responses are strictly in order.
  - Fully pipelined: back-to-back commands give back-to-back responses.
- Read, cmd_addr < DEPTH: rsp_rdata = array[cmd_addr] as of the acceptance edge; rsp_err=0.
- Write, cmd_addr < DEPTH:
  - For each byte i with cmd_be[i]=1, array byte i is updated at the acceptance edge; other bytes are unchanged.
  - Response has rsp_rdata=0, rsp_err=0.
- cmd_addr >= DEPTH (read or write): no array access; response has rsp_err=1, rsp_rdata=0.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
- Boundary cases:
  - Write then read of the same address on consecutive cycles: the read returns the new data.
  - clear_start and a fired command on the same edge: the command executes first and its response is still delivered on schedule; CLEAR starts on the next edge.
  - Responses of commands accepted before CLEAR still emerge during CLEAR.
  - A write with cmd_be all zero leaves the array unchanged but still responds.
  - DEPTH < 2**ADDR_WIDTH: the top address range returns rsp_err.
  - Counter width is ceil(log2(DEPTH)) (minimum 1); no wrap beyond DEPTH-1.
- Reset mid-operation:
  - Aborts the sweep and drops in-flight responses.
  - Array contents are undefined except where CLEAR_ON_RESET re-zeros them.

Test Plan:
1. Defaults. Release reset_n -> busy=1 and cmd_ready=0 for exactly 2048 cycles, then cmd_ready=1. Read addr 0x7FF -> rsp_rdata=0x00, rsp_err=0, after 1 cycle.
2. DATA_WIDTH=32, READ_LATENCY=3:
   - Write addr 5, 0xDEADBEEF, be=4'hF, then write addr 5, 0x11223344, be=4'b0101.
   - Read addr 5 -> rsp_rdata=0xDE22BE44 exactly 3 cycles after acceptance.
3. Back-to-back stream, READ_LATENCY=2: writes to addr 1..4 with data 0xA1..0xA4, then reads 1..4 on consecutive cycles -> four consecutive rsp_valid cycles carrying 0xA1, 0xA2, 0xA3, 0xA4 in order.
4. DEPTH=1000, ADDR_WIDTH=10:
   - Write addr 1000 -> rsp_err=1.
   - Read addr 1023 -> rsp_err=1, rsp_rdata=0.
   - Read addr 999 -> rsp_err=0.
5. Clear collision: with data present, assert clear_start together with a read of addr 3 (value 0x5A) -> read response 0x5A; busy=1 for DEPTH cycles; then read addr 3 -> 0x00.
6. Reset mid-sweep and mid-pipeline:
   - Pulse reset_n low at sweep counter 100 -> all outputs 0 immediately, no stale rsp_valid.
   - Sweep restarts from 0 and lasts the full DEPTH cycles.
